// File: rtl/core_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshake signals around core_mem_arbiter.
// slave = arbiter view, master = environment (core + memory) view.
interface core_mem_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_resp_valid;
    logic [31:0] if_rdata;

    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_wdata;
    logic        ls_resp_valid;
    logic [31:0] ls_rdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr, if_flush,
        output if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_valid, ls_addr, ls_we, ls_be, ls_wdata,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output if_req_valid, if_addr, if_flush,
        input  if_req_ready, if_resp_valid, if_rdata,
        output ls_req_valid, ls_addr, ls_we, ls_be, ls_wdata,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store (LS priority,
// bounded fetch starvation). Define CORE_MEM_ARB_PERF_CNT_EN to add grant/stall counters.
module core_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    core_mem_arbiter_if.slave bus
`ifdef CORE_MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       if_grant_cnt,
    output logic [31:0]       ls_grant_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    owner_t           owner_q;
    logic [CNT_W-1:0] starve_cnt_q;
    logic             flushed_q;
    logic [31:0]      mem_addr_q;
    logic             mem_we_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;

    logic             if_req_eff;
    logic             grant_if, grant_ls;
    logic             if_resp, ls_resp;
    logic [31:0]      if_rdata_c, ls_rdata_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? v : v + CNT_W'(1);
    endfunction

    // A flush in the request cycle withdraws the fetch request.
    assign if_req_eff = bus.if_req_valid & ~bus.if_flush;

    always_comb begin
        state_d    = state_q;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        if_resp    = 1'b0;
        ls_resp    = 1'b0;
        if_rdata_c = '0;
        ls_rdata_c = '0;
        unique case (state_q)
            S_IDLE: begin
                // Readys stay low while reset is held, since they are combinational.
                if (!rst) begin
                    if (if_req_eff && (!bus.ls_req_valid || starve_cnt_q >= LIMIT))
                        grant_if = 1'b1;
                    else if (bus.ls_req_valid)
                        grant_ls = 1'b1;
                end
                if (grant_if || grant_ls)
                    state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.mem_req_ready)
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.mem_resp_valid) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_IF) begin
                        if_resp    = ~(flushed_q | bus.if_flush);
                        if_rdata_c = bus.mem_rdata;
                    end else begin
                        ls_resp    = 1'b1;
                        ls_rdata_c = bus.mem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            flushed_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_if) begin
                owner_q      <= OWN_IF;
                mem_addr_q   <= bus.if_addr;
                mem_we_q     <= 1'b0;
                mem_be_q     <= 4'hF;
                mem_wdata_q  <= '0;
                starve_cnt_q <= '0;
            end else if (grant_ls) begin
                owner_q     <= OWN_LS;
                mem_addr_q  <= bus.ls_addr;
                mem_we_q    <= bus.ls_we;
                mem_be_q    <= bus.ls_be;
                mem_wdata_q <= bus.ls_wdata;
                if (if_req_eff)
                    starve_cnt_q <= sat_inc(starve_cnt_q);
            end
            // The transaction always runs to completion; a flush only hides its response.
            if (state_d == S_IDLE)
                flushed_q <= 1'b0;
            else if (state_q != S_IDLE && owner_q == OWN_IF && bus.if_flush)
                flushed_q <= 1'b1;
        end
    end

    assign bus.if_req_ready  = grant_if;
    assign bus.ls_req_ready  = grant_ls;
    assign bus.if_resp_valid = if_resp;
    assign bus.ls_resp_valid = ls_resp;
    assign bus.if_rdata      = if_rdata_c;
    assign bus.ls_rdata      = ls_rdata_c;
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_be        = mem_be_q;
    assign bus.mem_wdata     = mem_wdata_q;

`ifdef CORE_MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_grant_cnt <= '0;
            ls_grant_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (grant_if)
                if_grant_cnt <= if_grant_cnt + 32'd1;
            if (grant_ls)
                ls_grant_cnt <= ls_grant_cnt + 32'd1;
            if (state_q == S_REQ && !bus.mem_req_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: vector table, arbitration scoreboard, corner sequences.
module tb_core_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_mem_arbiter_if bus ();

`ifdef CORE_MEM_ARB_PERF_CNT_EN
    logic [31:0] if_grant_cnt, ls_grant_cnt, stall_cnt;
`endif

    core_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CORE_MEM_ARB_PERF_CNT_EN
        ,
        .if_grant_cnt (if_grant_cnt),
        .ls_grant_cnt (ls_grant_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = '0;
        bus.if_flush       = 1'b0;
        bus.ls_req_valid   = 1'b0;
        bus.ls_addr        = '0;
        bus.ls_we          = 1'b0;
        bus.ls_be          = '0;
        bus.ls_wdata       = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, ".if_req_ready"}, bus.if_req_ready, 1'b0);
        chk1({tag, ".ls_req_ready"}, bus.ls_req_ready, 1'b0);
        chk1({tag, ".if_resp_valid"}, bus.if_resp_valid, 1'b0);
        chk1({tag, ".ls_resp_valid"}, bus.ls_resp_valid, 1'b0);
        chk1({tag, ".mem_req_valid"}, bus.mem_req_valid, 1'b0);
        chk32({tag, ".mem_addr"}, bus.mem_addr, 32'h0);
        chk1({tag, ".mem_we"}, bus.mem_we, 1'b0);
        chk32({tag, ".mem_be"}, {28'h0, bus.mem_be}, 32'h0);
        chk32({tag, ".mem_wdata"}, bus.mem_wdata, 32'h0);
        chk32({tag, ".if_rdata"}, bus.if_rdata, 32'h0);
        chk32({tag, ".ls_rdata"}, bus.ls_rdata, 32'h0);
    endtask

    // One cycle of stimulus and the outputs required during that same cycle.
    typedef struct {
        logic ifv; logic [31:0] ifa; logic fl;
        logic lsv; logic [31:0] lsa; logic we; logic [3:0] be; logic [31:0] wd;
        logic mrr; logic mrsp; logic [31:0] mrd;
        logic e_ifr; logic e_lsr; logic e_mrv; logic [31:0] e_ma; logic e_we; logic [3:0] e_be;
        logic [31:0] e_wd; logic e_ifrv; logic [31:0] e_ifrd; logic e_lsrv; logic [31:0] e_lsrd;
        logic chk_rd;
    } vec_t;

    localparam int NV = 24;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    vec_t tv [NV];

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
    } resp_t;
    resp_t sb [$];

    initial begin
        // Single fetch, minimum latency.
        tv[0]  = '{H,32'h100,L, L,Z,L,4'h0,Z, H,L,Z, H,L,L,Z,L,4'h0,Z, L,Z,L,Z,L};
        tv[1]  = '{L,Z,L, L,Z,L,4'h0,Z, H,L,Z, L,L,H,32'h100,L,4'hF,Z, L,Z,L,Z,L};
        tv[2]  = '{L,Z,L, L,Z,L,4'h0,Z, L,H,32'hDEADBEEF, L,L,L,32'h100,L,4'hF,Z, H,32'hDEADBEEF,L,Z,L};
        // Store with 3 stall cycles; stray mem_resp_valid in IDLE/REQ, fetch pending during it.
        tv[3]  = '{L,Z,L, H,32'h2000,H,4'h3,32'h1234, L,H,32'h55, L,H,L,32'h100,L,4'hF,Z, L,Z,L,Z,L};
        tv[4]  = '{H,32'h700,L, L,Z,L,4'h0,Z, L,H,32'h66, L,L,H,32'h2000,H,4'h3,32'h1234, L,Z,L,Z,L};
        tv[5]  = '{H,32'h700,L, L,Z,L,4'h0,Z, L,L,Z, L,L,H,32'h2000,H,4'h3,32'h1234, L,Z,L,Z,L};
        tv[6]  = '{H,32'h700,L, L,Z,L,4'h0,Z, L,L,Z, L,L,H,32'h2000,H,4'h3,32'h1234, L,Z,L,Z,L};
        tv[7]  = '{H,32'h700,L, L,Z,L,4'h0,Z, H,L,Z, L,L,H,32'h2000,H,4'h3,32'h1234, L,Z,L,Z,L};
        tv[8]  = '{H,32'h700,L, L,Z,L,4'h0,Z, L,L,Z, L,L,L,32'h2000,H,4'h3,32'h1234, L,Z,L,Z,L};
        tv[9]  = '{H,32'h700,L, L,Z,L,4'h0,Z, L,H,32'hCAFEF00D, L,L,L,32'h2000,H,4'h3,32'h1234, L,Z,H,Z,L};
        tv[10] = '{H,32'h300,L, L,Z,L,4'h0,Z, H,L,Z, H,L,L,32'h2000,H,4'h3,32'h1234, L,Z,L,Z,L};
        tv[11] = '{L,Z,L, L,Z,L,4'h0,Z, H,L,Z, L,L,H,32'h300,L,4'hF,Z, L,Z,L,Z,L};
        tv[12] = '{L,Z,L, L,Z,L,4'h0,Z, L,H,32'h11112222, L,L,L,32'h300,L,4'hF,Z, H,32'h11112222,L,Z,L};
        // Fetch flushed in REQ still completes on the bus but returns nothing.
        tv[13] = '{H,32'h400,L, L,Z,L,4'h0,Z, L,L,Z, H,L,L,32'h300,L,4'hF,Z, L,Z,L,Z,L};
        tv[14] = '{L,Z,H, L,Z,L,4'h0,Z, L,L,Z, L,L,H,32'h400,L,4'hF,Z, L,Z,L,Z,L};
        tv[15] = '{L,Z,L, L,Z,L,4'h0,Z, H,L,Z, L,L,H,32'h400,L,4'hF,Z, L,Z,L,Z,L};
        tv[16] = '{L,Z,L, L,Z,L,4'h0,Z, L,H,32'hBAD0BAD0, L,L,L,32'h400,L,4'hF,Z, L,Z,L,Z,L};
        tv[17] = '{H,32'h500,L, L,Z,L,4'h0,Z, H,L,Z, H,L,L,32'h400,L,4'hF,Z, L,Z,L,Z,L};
        tv[18] = '{L,Z,L, L,Z,L,4'h0,Z, H,L,Z, L,L,H,32'h500,L,4'hF,Z, L,Z,L,Z,L};
        tv[19] = '{L,Z,L, L,Z,L,4'h0,Z, L,H,32'h12345678, L,L,L,32'h500,L,4'hF,Z, H,32'h12345678,L,Z,L};
        // Flush in IDLE masks fetch; flush during an LS transaction is ignored.
        tv[20] = '{H,32'h900,H, L,Z,L,4'h0,Z, L,L,Z, L,L,L,32'h500,L,4'hF,Z, L,Z,L,Z,L};
        tv[21] = '{H,32'h900,H, H,32'h600,L,4'hF,Z, H,L,Z, L,H,L,32'h500,L,4'hF,Z, L,Z,L,Z,L};
        tv[22] = '{L,Z,H, L,Z,L,4'h0,Z, H,L,Z, L,L,H,32'h600,L,4'hF,Z, L,Z,L,Z,L};
        tv[23] = '{L,Z,H, L,Z,L,4'h0,Z, L,H,32'hAABBCCDD, L,L,L,32'h600,L,4'hF,Z, L,Z,H,32'hAABBCCDD,H};
    end

    logic exp_ls_win [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        resp_t r;
        logic  any_resp;

        idle_inputs();
        rst = 1'b1;
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        tick();
        tick();
        #3;
        chk_all_zero("reset");
        tick();
        idle_inputs();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.if_req_valid   = tv[i].ifv;
            bus.if_addr        = tv[i].ifa;
            bus.if_flush       = tv[i].fl;
            bus.ls_req_valid   = tv[i].lsv;
            bus.ls_addr        = tv[i].lsa;
            bus.ls_we          = tv[i].we;
            bus.ls_be          = tv[i].be;
            bus.ls_wdata       = tv[i].wd;
            bus.mem_req_ready  = tv[i].mrr;
            bus.mem_resp_valid = tv[i].mrsp;
            bus.mem_rdata      = tv[i].mrd;
            #3;
            chk1($sformatf("v%0d.if_req_ready", i), bus.if_req_ready, tv[i].e_ifr);
            chk1($sformatf("v%0d.ls_req_ready", i), bus.ls_req_ready, tv[i].e_lsr);
            chk1($sformatf("v%0d.mem_req_valid", i), bus.mem_req_valid, tv[i].e_mrv);
            chk32($sformatf("v%0d.mem_addr", i), bus.mem_addr, tv[i].e_ma);
            chk1($sformatf("v%0d.mem_we", i), bus.mem_we, tv[i].e_we);
            chk32($sformatf("v%0d.mem_be", i), {28'h0, bus.mem_be}, {28'h0, tv[i].e_be});
            chk32($sformatf("v%0d.mem_wdata", i), bus.mem_wdata, tv[i].e_wd);
            chk1($sformatf("v%0d.if_resp_valid", i), bus.if_resp_valid, tv[i].e_ifrv);
            chk1($sformatf("v%0d.ls_resp_valid", i), bus.ls_resp_valid, tv[i].e_lsrv);
            if (tv[i].e_ifrv)
                chk32($sformatf("v%0d.if_rdata", i), bus.if_rdata, tv[i].e_ifrd);
            if (tv[i].e_lsrv && tv[i].chk_rd)
                chk32($sformatf("v%0d.ls_rdata", i), bus.ls_rdata, tv[i].e_lsrd);
            tick();
        end
        idle_inputs();

        // Both requesters always valid: LS x4 then IF, repeating.
        for (int t = 0; t < 10; t++) begin
            bus.if_req_valid   = 1'b1;
            bus.ls_req_valid   = 1'b1;
            bus.if_addr        = 32'h1000 + 32'(t * 4);
            bus.ls_addr        = 32'h8000 + 32'(t * 4);
            bus.ls_be          = 4'hF;
            bus.mem_req_ready  = 1'b1;
            bus.mem_resp_valid = 1'b0;
            #3;
            chk1($sformatf("arb%0d.ls_req_ready", t), bus.ls_req_ready, exp_ls_win[t]);
            chk1($sformatf("arb%0d.if_req_ready", t), bus.if_req_ready, ~exp_ls_win[t]);
            if (bus.ls_req_ready)
                sb.push_back('{1'b1, bus.ls_addr ^ KEY});
            else if (bus.if_req_ready)
                sb.push_back('{1'b0, bus.if_addr ^ KEY});
            tick();
            tick();
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = bus.mem_addr ^ KEY;
            #3;
            any_resp = bus.if_resp_valid | bus.ls_resp_valid;
            chk1($sformatf("arb%0d.resp_seen", t), any_resp, 1'b1);
            if (any_resp) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL arb%0d.unexpected_resp: got response expected none", t);
                end else begin
                    r = sb.pop_front();
                    chk1($sformatf("arb%0d.owner_is_ls", t), bus.ls_resp_valid, r.is_ls);
                    chk32($sformatf("arb%0d.rdata", t),
                          r.is_ls ? bus.ls_rdata : bus.if_rdata, r.data);
                end
            end
            tick();
        end
        idle_inputs();
        chk32("arb.sb_empty", 32'(sb.size()), 32'h0);

        // Reset while waiting for a response drops the transaction.
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'hC00;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.if_req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.if_req_valid  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_resp");
        tick();
        rst = 1'b0;
        bus.if_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h77;
        #3;
        chk1("rst_resp.late_if_resp", bus.if_resp_valid, 1'b0);
        chk1("rst_resp.late_ls_resp", bus.ls_resp_valid, 1'b0);
        tick();
        idle_inputs();

`ifdef CORE_MEM_ARB_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) begin
                bus.if_req_valid = 1'b1;
                bus.if_addr      = 32'h40 + 32'(k * 4);
            end else begin
                bus.ls_req_valid = 1'b1;
                bus.ls_addr      = 32'h80 + 32'(k * 4);
                bus.ls_be        = 4'hF;
            end
            tick();
            bus.if_req_valid = 1'b0;
            bus.ls_req_valid = 1'b0;
            tick();
            tick();
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b1;
            tick();
            bus.mem_resp_valid = 1'b0;
        end
        #3;
        chk32("perf.if_grant_cnt", if_grant_cnt, 32'd3);
        chk32("perf.ls_grant_cnt", ls_grant_cnt, 32'd2);
        chk32("perf.stall_cnt", stall_cnt, 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the load/store unit (LS).
- Single outstanding transaction. Load/store has priority, with a bounded-starvation guarantee for fetch.
- Holds each accepted request stable toward memory and routes the response back to its owner.
- Supports cancelling an in-flight fetch on a redirect.

Parameters:
- STARVE_LIMIT, 4: consecutive contested LS grants before IF is forced to win. 0 = IF always wins a contest.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch word address
- if_flush  in  1  cancel the in-flight fetch
- if_resp_valid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  32  fetch data
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_addr  in  32  data address
- ls_we  in  1  1 = store
- ls_be  in  4  byte enables
- ls_wdata  in  32  store data
- ls_resp_valid  out  1  load data or store ack (1-cycle pulse)
- ls_rdata  out  32  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr  out  32  registered address
- mem_we  out  1  registered write enable
- mem_be  out  4  registered byte enables
- mem_wdata  out  32  registered store data
- mem_resp_valid  in  1  memory response
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=IF, starve_cnt=0, flushed=0. All outputs 0: both readys, both resp_valids, mem_req_valid, mem_addr/we/be/wdata, rdata outputs.
- Reset mid-transaction drops the transaction silently; no response is produced.
- FSM states: IDLE, REQ, RESP.
- IDLE arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: IF wins if starve_cnt >= STARVE_LIMIT, otherwise LS wins.
  - Winner's ready=1 combinationally this cycle. Request fields are registered (IF: we=0, be=4'hF, wdata=0). Owner is recorded. Next state REQ.
  - if_flush=1 in IDLE masks if_req_valid for that cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each IDLE grant to LS while if_req_valid=1.
  - Cleared on any IF grant.
  - Otherwise unchanged.
- REQ: mem_req_valid=1 with fields held stable until mem_req_ready=1, then next state RESP. mem_req_valid is low in IDLE and RESP.
- RESP: on mem_resp_valid=1, mem_rdata is forwarded combinationally to the owner's rdata; owner's resp_valid=1 for that cycle; next state IDLE.
  - A store also completes with ls_resp_valid=1 (rdata don't-care).
- Readys are 0 outside IDLE. No new grant occurs in the cycle a response returns; arbitration resumes the next cycle.
- Minimum latency: grant at cycle N, mem_req_valid at N+1 (with mem_req_ready=1 at N+1), response at N+2 at the earliest.
- Flush: if_flush=1 while owner=IF in REQ or RESP sets the flushed flag.
  - The FSM still completes the memory transaction: no abort mid-REQ, since memory may have accepted.
  - if_resp_valid is suppressed for the response.
  - The flag clears on return to IDLE.
  - if_flush while owner=LS has no effect.
- mem_resp_valid in IDLE or REQ is ignored.
- Widths: all data paths are 32 bits; no arithmetic besides the counter.

Optional Feature:
- Macro CORE_MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs if_grant_cnt (32, out), ls_grant_cnt (32, out), stall_cnt (32, out). All reset to 0 and wrap modulo 2^32.
  - Grant counters increment on each respective grant.
  - stall_cnt increments each cycle in REQ with mem_req_ready=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RESP: rst pulsed while waiting for a response → all outputs 0 immediately. A later mem_resp_valid in IDLE produces no resp_valid.
- Single fetch to addr 0x100, memory ready immediately, responds with 0xDEADBEEF one cycle later → if_req_ready at N, mem_req_valid/mem_addr=0x100/mem_be=4'hF at N+1, if_resp_valid with if_rdata=0xDEADBEEF at N+2.
- Both requesters held valid continuously with STARVE_LIMIT=4 → grant pattern LS,LS,LS,LS,IF repeating. starve_cnt returns to 0 after each IF grant.
- Store addr 0x2000, be=4'b0011, wdata=0x1234, mem_req_ready low for 3 cycles → mem_* fields stable for 4 cycles. Single ls_resp_valid pulse after mem_resp_valid. if_resp_valid never asserts.
- Fetch granted, if_flush pulsed in REQ → transaction still issued to memory. mem_resp_valid produces no if_resp_valid. The next fetch is granted and returns data normally.
- With CORE_MEM_ARB_PERF_CNT_EN defined: 3 fetches and 2 loads, mem_req_ready held low 2 cycles each → if_grant_cnt=3, ls_grant_cnt=2, stall_cnt=10.
